// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory bank.
// Byte-lane masks and load extension are sized for the widest build (64-bit
// words, 8 lanes); narrower builds take the low slices.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

    localparam int MAX_W     = 64;
    localparam int MAX_LANES = MAX_W / 8;

    // Byte-enable mask of an access starting at 'lane', two words wide:
    // bits [LANES-1:0] hit the addressed word, bits above spill into the next.
    function automatic logic [2*MAX_LANES-1:0] lane_mask(input logic [2:0] lane,
                                                         input logic [1:0] size);
        logic [2*MAX_LANES-1:0] ones;
        ones = (16'd1 << (4'd1 << size)) - 16'd1;
        return ones << lane;
    endfunction

    // Sign- or zero-extend a right-justified load from its top data bit.
    function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] data,
                                                input logic [1:0]       size,
                                                input logic             is_unsigned);
        logic [MAX_W-1:0] r;
        case (size)
            SZ_BYTE: r = {{56{~is_unsigned & data[7]}},  data[7:0]};
            SZ_HALF: r = {{48{~is_unsigned & data[15]}}, data[15:0]};
            SZ_WORD: r = {{32{~is_unsigned & data[31]}}, data[31:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane alignment for the data memory bank.
// Store side: rotates right-justified store data up to its starting lane and
// produces the byte enables for the addressed word and the following word.
// Load side: rotates the (possibly two-beat merged) word down to bit 0 and
// extends it. The rotated store data is the same for both beats of a split
// access; only the enables differ.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          st_lane,
    input  logic [1:0]          st_size,
    input  logic [DATA_W-1:0]   st_wdata,
    output logic [DATA_W-1:0]   st_wdata_rot,
    output logic [DATA_W/8-1:0] st_be_low,
    output logic [DATA_W/8-1:0] st_be_high,
    input  logic [2:0]          ld_lane,
    input  logic [1:0]          ld_size,
    input  logic                ld_unsigned,
    input  logic [DATA_W-1:0]   ld_word,
    output logic [DATA_W-1:0]   ld_data
);
    localparam int LANES = DATA_W / 8;

    logic [2*DATA_W-1:0]      st_dbl;
    logic [2*DATA_W-1:0]      ld_dbl;
    logic [2*MAX_LANES-1:0]   st_mask;
    logic [5:0]               st_shift;
    logic [5:0]               ld_shift;

    // Store path: left-rotate by the lane offset, split the mask per word.
    always_comb begin
        st_shift     = {st_lane, 3'b000};
        st_dbl       = {st_wdata, st_wdata} << st_shift;
        st_wdata_rot = st_dbl[2*DATA_W-1:DATA_W];
        st_mask      = lane_mask(st_lane, st_size);
        st_be_low    = st_mask[LANES-1:0];
        st_be_high   = st_mask[2*LANES-1:LANES];
    end

    // Load path: right-rotate the selected bytes to bit 0, then extend.
    always_comb begin
        ld_shift = {ld_lane, 3'b000};
        ld_dbl   = {ld_word, ld_word} >> ld_shift;
        ld_data  = DATA_W'(extend(64'(ld_dbl[DATA_W-1:0]), ld_size, ld_unsigned));
    end

endmodule

// File: rtl/data_memory_bank.sv
// Byte-addressed, word-organised single-port data memory for the MIPS datapath.
// One byte RAM per lane with registered read; responses appear one cycle after
// acceptance. Build option DMEM_MISALIGN_SPLIT_EN turns accesses that cross a
// word boundary into a two-beat SPLIT sequence; without it they are rejected.
// INIT_FILE names the byte image used for simulation/backdoor preload; the
// array itself is never reset.
module data_memory_bank
    import dmem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = "data_memory.txt"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);
    localparam int          LANES  = DATA_W / 8;
    localparam int          LANE_W = $clog2(LANES);
    localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] CAP    = 33'(DEPTH * LANES);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [2:0]  req_lane;
    logic [3:0]  req_nbytes;
    logic [31:0] req_word;
    logic [32:0] req_last;
    logic        size_bad;
    logic        range_bad;
    logic        req_cross;
    logic        req_err;
    logic        accept;

    // Word index, lane, byte count and the reasons an access is rejected.
    always_comb begin
        req_lane   = req_addr[2:0] & 3'(LANES - 1);
        req_nbytes = 4'd1 << req_size;
        req_word   = req_addr >> LANE_W;
        req_last   = {1'b0, req_addr} + {29'd0, req_nbytes} - 33'd1;
        size_bad   = (req_size == SZ_DWORD) && (DATA_W != 64);
        range_bad  = req_last >= CAP;
        req_cross  = ({1'b0, req_lane} + req_nbytes) > 4'(LANES);
`ifdef DMEM_MISALIGN_SPLIT_EN
        req_err    = size_bad || range_bad;
`else
        req_err    = size_bad || range_bad || req_cross;
`endif
    end

    assign accept = req_valid && req_ready;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              rsp_load_q,  rsp_load_d;
    logic [2:0]        ld_lane_q,   ld_lane_d;
    logic [1:0]        ld_size_q,   ld_size_d;
    logic              ld_uns_q,    ld_uns_d;

`ifdef DMEM_MISALIGN_SPLIT_EN
    state_e            state_q,       state_d;
    logic [AW-1:0]     split_idx_q,   split_idx_d;
    logic [LANES-1:0]  split_be_q,    split_be_d;
    logic [DATA_W-1:0] split_wdata_q, split_wdata_d;
    logic              split_we_q,    split_we_d;
    logic              rsp_split_q,   rsp_split_d;
    logic [DATA_W-1:0] low_q,         low_d;
`endif

    // RAM port and alignment wiring
    logic [AW-1:0]     ram_addr;
    logic              ram_re;
    logic [LANES-1:0]  ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] st_wdata_rot;
    logic [LANES-1:0]  st_be_low;
    logic [LANES-1:0]  st_be_high;
    logic [DATA_W-1:0] ld_word;
    logic [DATA_W-1:0] ld_data;

    dmem_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .st_lane      (req_lane),
        .st_size      (req_size),
        .st_wdata     (req_wdata),
        .st_wdata_rot (st_wdata_rot),
        .st_be_low    (st_be_low),
        .st_be_high   (st_be_high),
        .ld_lane      (ld_lane_q),
        .ld_size      (ld_size_q),
        .ld_unsigned  (ld_uns_q),
        .ld_word      (ld_word),
        .ld_data      (ld_data)
    );

    // ------------------------------------------------------------------
    // Byte-lane RAMs (read-first, registered read) and load merge
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            // One byte per word per lane; the read returns pre-edge contents.
            always_ff @(posedge clk) begin
                if (ram_be[gi]) begin
                    mem[ram_addr] <= ram_wdata[8*gi +: 8];
                end
                if (ram_re) begin
                    rd_q <= mem[ram_addr];
                end
            end

            assign ram_rdata[8*gi +: 8] = rd_q;

`ifdef DMEM_MISALIGN_SPLIT_EN
            // After a split, lanes at/above the start lane came from the low
            // word (beat0, latched); lanes below it came from the next word.
            assign ld_word[8*gi +: 8] = (rsp_split_q && (3'(gi) >= ld_lane_q))
                                      ? low_q[8*gi +: 8] : rd_q;
`else
            assign ld_word[8*gi +: 8] = rd_q;
`endif
        end
    endgenerate

`ifdef DMEM_MISALIGN_SPLIT_EN
    // ------------------------------------------------------------------
    // FSM: IDLE -> SPLIT for an accepted crossing access, back after beat1
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !req_err && req_cross) state_d = SPLIT;
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = !rst && (state_q == IDLE);
`else
    assign req_ready = !rst;
`endif

    // ------------------------------------------------------------------
    // Outputs: RAM port control, beat latches and response capture
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr    = req_err ? '0 : req_word[AW-1:0];
        ram_re      = 1'b0;
        ram_be      = '0;
        ram_wdata   = st_wdata_rot;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_load_d  = rsp_load_q;
        ld_lane_d   = ld_lane_q;
        ld_size_d   = ld_size_q;
        ld_uns_d    = ld_uns_q;
`ifdef DMEM_MISALIGN_SPLIT_EN
        split_idx_d   = split_idx_q;
        split_be_d    = split_be_q;
        split_wdata_d = split_wdata_q;
        split_we_d    = split_we_q;
        rsp_split_d   = rsp_split_q;
        low_d         = low_q;

        if (state_q == SPLIT) begin
            // Beat1: next word; keep beat0's read data for the merge.
            ram_addr    = split_idx_q;
            ram_re      = 1'b1;
            ram_be      = split_we_q ? split_be_q : '0;
            ram_wdata   = split_wdata_q;
            low_d       = ram_rdata;
            rsp_valid_d = 1'b1;
        end else
`endif
        if (accept) begin
            rsp_load_d = !req_we && !req_err;
            ld_lane_d  = req_lane;
            ld_size_d  = req_size;
            ld_uns_d   = req_unsigned;
            if (req_err) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end else begin
                // In-word access, or beat0 of a crossing one.
                ram_re = 1'b1;
                ram_be = req_we ? st_be_low : '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
                rsp_split_d = req_cross;
                if (req_cross) begin
                    split_idx_d   = req_word[AW-1:0] + AW'(1);
                    split_be_d    = st_be_high;
                    split_wdata_d = st_wdata_rot;
                    split_we_d    = req_we;
                end else begin
                    rsp_valid_d = 1'b1;
                end
`else
                rsp_valid_d = 1'b1;
`endif
            end
        end

        // Nothing is written while reset is held (drops a pending beat1).
        if (rst) begin
            ram_be = '0;
        end
    end

    // Response and beat-latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_load_q    <= 1'b0;
            ld_lane_q     <= '0;
            ld_size_q     <= '0;
            ld_uns_q      <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
            split_idx_q   <= '0;
            split_be_q    <= '0;
            split_wdata_q <= '0;
            split_we_q    <= 1'b0;
            rsp_split_q   <= 1'b0;
            low_q         <= '0;
`endif
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_load_q    <= rsp_load_d;
            ld_lane_q     <= ld_lane_d;
            ld_size_q     <= ld_size_d;
            ld_uns_q      <= ld_uns_d;
`ifdef DMEM_MISALIGN_SPLIT_EN
            split_idx_q   <= split_idx_d;
            split_be_q    <= split_be_d;
            split_wdata_q <= split_wdata_d;
            split_we_q    <= split_we_d;
            rsp_split_q   <= rsp_split_d;
            low_q         <= low_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && rsp_load_q) ? ld_data : '0;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed bench for data_memory_bank (DATA_W=32, DEPTH=256, 1 KiB).
// Expectations follow DMEM_MISALIGN_SPLIT_EN when the build defines it.
module tb_data_memory_bank;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    data_memory_bank #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE ("data_memory.txt")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One request: drive at negedge, accept on the following posedge, then
    // count posedges until rsp_valid (bounded). Samples 1 ns after each edge.
    task automatic xfer(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int ready_low);
        int guard;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        guard = 0;
        while (!req_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wdata = '0;
        lat       = 1;
        ready_low = 0;
        while (!rsp_valid && lat < 8) begin
            if (!req_ready) ready_low++;
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        $display("xfer %-12s we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 name, we, size, uns, addr, wdata, rdata, err, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          rl;
        logic [31:0] exp_w10;

        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        // 1. Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err",   rsp_err,   0);
        rst = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);

        // 2. Word store / load, latency 1
        xfer("st_w_10", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, rl);
        check("st_w_10_err",   er,  0);
        check("st_w_10_lat",   lat, 1);
        check("st_w_10_rdata", rd,  0);
        @(posedge clk); #1;
        check("rsp_pulse_one", rsp_valid, 0);
        xfer("ld_w_10", 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, rl);
        check("ld_w_10_data", rd,  32'hDEADBEEF);
        check("ld_w_10_lat",  lat, 1);
        check("ld_w_10_err",  er,  0);

        // 3. Sub-word loads with extension
        xfer("ld_b_13_s", 0, 2'd0, 0, 32'h13, 32'h0, rd, er, lat, rl);
        check("ld_b_13_s", rd, 32'hFFFFFFDE);
        xfer("ld_b_13_u", 0, 2'd0, 1, 32'h13, 32'h0, rd, er, lat, rl);
        check("ld_b_13_u", rd, 32'h000000DE);
        xfer("ld_h_12_s", 0, 2'd1, 0, 32'h12, 32'h0, rd, er, lat, rl);
        check("ld_h_12_s", rd, 32'hFFFFDEAD);
        xfer("ld_h_10_u", 0, 2'd1, 1, 32'h10, 32'h0, rd, er, lat, rl);
        check("ld_h_10_u", rd, 32'h0000BEEF);
        xfer("ld_b_10_s", 0, 2'd0, 0, 32'h10, 32'h0, rd, er, lat, rl);
        check("ld_b_10_s", rd, 32'hFFFFFFEF);

        // 4. Partial stores leave other lanes alone; back-to-back store/load
        xfer("st_b_11", 1, 2'd0, 0, 32'h11, 32'h0000005A, rd, er, lat, rl);
        xfer("ld_w_10b", 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, rl);
        check("st_b_lane", rd, 32'hDEAD5AEF);
        xfer("st_h_12", 1, 2'd1, 0, 32'h12, 32'hFFFF8001, rd, er, lat, rl);
        xfer("ld_w_10c", 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, rl);
        check("st_h_lane", rd, 32'h80015AEF);
        xfer("ld_h_12_s2", 0, 2'd1, 0, 32'h12, 32'h0, rd, er, lat, rl);
        check("ld_h_12_s2", rd, 32'hFFFF8001);

        // 5. Word-crossing access
        xfer("st_w_0c", 1, 2'd2, 0, 32'h0C, 32'h01020304, rd, er, lat, rl);
`ifdef DMEM_MISALIGN_SPLIT_EN
        xfer("st_w_0e", 1, 2'd2, 0, 32'h0E, 32'h11223344, rd, er, lat, rl);
        check("split_st_err",   er,  0);
        check("split_st_lat",   lat, 2);
        check("split_st_ready", rl,  1);
        xfer("ld_w_0e", 0, 2'd2, 0, 32'h0E, 32'h0, rd, er, lat, rl);
        check("split_ld_data",  rd,  32'h11223344);
        check("split_ld_lat",   lat, 2);
        check("split_ld_ready", rl,  1);
        xfer("ld_w_0c", 0, 2'd2, 0, 32'h0C, 32'h0, rd, er, lat, rl);
        check("split_low_word", rd, 32'h33440304);
        xfer("ld_w_10d", 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, rl);
        check("split_high_word", rd, 32'h80011122);
        xfer("ld_h_0f_u", 0, 2'd1, 1, 32'h0F, 32'h0, rd, er, lat, rl);
        check("split_ld_half", rd, 32'h00002233);
        exp_w10 = 32'h80011122;
`else
        xfer("st_w_0e", 1, 2'd2, 0, 32'h0E, 32'h11223344, rd, er, lat, rl);
        check("cross_st_err",   er,  1);
        check("cross_st_lat",   lat, 1);
        check("cross_st_rdata", rd,  0);
        xfer("ld_w_0c", 0, 2'd2, 0, 32'h0C, 32'h0, rd, er, lat, rl);
        check("cross_low_intact", rd, 32'h01020304);
        xfer("ld_w_10d", 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, rl);
        check("cross_high_intact", rd, 32'h80015AEF);
        xfer("ld_h_0f_u", 0, 2'd1, 1, 32'h0F, 32'h0, rd, er, lat, rl);
        check("cross_ld_err",   er, 1);
        check("cross_ld_rdata", rd, 0);
        exp_w10 = 32'h80015AEF;
`endif

        // 6. Range and size errors
        xfer("ld_w_400", 0, 2'd2, 0, 32'h400, 32'h0, rd, er, lat, rl);
        check("oor_err",   er,  1);
        check("oor_rdata", rd,  0);
        check("oor_lat",   lat, 1);
        xfer("ld_b_3ff", 0, 2'd0, 1, 32'h3FF, 32'h0, rd, er, lat, rl);
        check("last_byte_ok", er, 0);
        xfer("ld_w_3fe", 0, 2'd2, 0, 32'h3FE, 32'h0, rd, er, lat, rl);
        check("end_cross_err", er, 1);
        xfer("st_d_10", 1, 2'd3, 0, 32'h10, 32'hFFFFFFFF, rd, er, lat, rl);
        check("dword_err", er, 1);
        xfer("st_b_400", 1, 2'd0, 0, 32'h400, 32'hFFFFFFFF, rd, er, lat, rl);
        check("oor_st_err", er, 1);
        xfer("ld_w_10e", 0, 2'd2, 0, 32'h10, 32'h0, rd, er, lat, rl);
        check("err_no_write", rd, exp_w10);

`ifdef DMEM_MISALIGN_SPLIT_EN
        // Reset between beat0 and beat1 of a split store.
        begin
            int saw;
            xfer("st_w_1c", 1, 2'd2, 0, 32'h1C, 32'h0, rd, er, lat, rl);
            xfer("st_w_20", 1, 2'd2, 0, 32'h20, 32'h0, rd, er, lat, rl);
            @(negedge clk);
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_size  = 2'd2;
            req_addr  = 32'h1E;
            req_wdata = 32'hAABBCCDD;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            req_we    = 1'b0;
            rst       = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            saw = 0;
            repeat (3) begin
                if (rsp_valid) saw = 1;
                @(posedge clk);
                #1;
            end
            $display("xfer rst_in_split addr=0000001e -> rsp_seen=%0d ready=%0d", saw, req_ready);
            check("rst_split_no_rsp", saw, 0);
            check("rst_split_ready", req_ready, 1);
            xfer("ld_h_1e_u", 0, 2'd1, 1, 32'h1E, 32'h0, rd, er, lat, rl);
            check("rst_split_beat0", rd, 32'h0000CCDD);
            xfer("ld_w_20", 0, 2'd2, 0, 32'h20, 32'h0, rd, er, lat, rl);
            check("rst_split_beat1", rd, 32'h00000000);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
